nn_layer_serializer: RTL and testbench

Inter-layer sequencer for the fully connected network. Captures the parallel output vector of one neuron layer in a single cycle and replays it as a serial one-word-per-cycle stream into the next layer's neuron inputs, which have no backpressure. One instance sits between each pair of layers (784→30→30→10→10 chain); the 10-wide final instance feeds the max finder.

---
 rtl/nn_pkg.sv | 12 +
 rtl/nn_layer_serializer.sv | 110 +++++++++++
 tb/tb_nn_layer_serializer.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/nn_pkg.sv
// Shared definitions for the fully connected network datapath.
package nn_pkg;

    localparam int unsigned DataWidth = 16;

    typedef enum logic [0:0] {IDLE, SEND} state_e;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/nn_layer_serializer.sv
// Captures a full layer output vector in one cycle and replays it one word per cycle,
// with gapless back-to-back capture on the last-word cycle.
module nn_layer_serializer
    import nn_pkg::*;
#(
    parameter int unsigned NUM_NEURONS = 30,
    parameter int unsigned DATA_WIDTH  = DataWidth,
    parameter int unsigned CNT_WIDTH   = 8
) (
    input  logic                              aclk,
    input  logic                              reset,
    input  logic                              cap_valid,
    input  logic [NUM_NEURONS*DATA_WIDTH-1:0] cap_data,
    output logic [DATA_WIDTH-1:0]             out_data,
    output logic                              out_valid,
    output logic                              out_last,
    output logic                              busy,
    output logic                              overrun,
    output logic [CNT_WIDTH-1:0]              vec_count
);

    localparam int unsigned IdxW = idx_width(NUM_NEURONS);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_NEURONS - 1);

    state_e                state_q, state_d;
    logic [IdxW-1:0]       idx_q, idx_d;
    logic [DATA_WIDTH-1:0] word_q [NUM_NEURONS];
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  out_valid_q, out_valid_d;
    logic                  out_last_q, out_last_d;
    logic                  overrun_q, overrun_d;
    logic [CNT_WIDTH-1:0]  vec_count_q, vec_count_d;
    logic                  at_last;
    logic                  capture;

    // idx_q names the word currently presented on out_data while in SEND.
    assign at_last = (state_q == SEND) && (idx_q == LastIdx);
    assign capture = cap_valid && ((state_q == IDLE) || at_last);

    always_ff @(posedge aclk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (cap_valid) state_d = SEND;
            SEND: if (at_last && !cap_valid) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        idx_d       = idx_q;
        out_data_d  = '0;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
        if (capture) begin
            idx_d       = '0;
            out_data_d  = cap_data[DATA_WIDTH-1:0];
            out_valid_d = 1'b1;
        end else if ((state_q == SEND) && !at_last) begin
            idx_d       = idx_q + IdxW'(1);
            out_data_d  = word_q[idx_d];
            out_valid_d = 1'b1;
            out_last_d  = (idx_d == LastIdx);
        end
        vec_count_d = vec_count_q + CNT_WIDTH'(at_last);
        overrun_d   = overrun_q | (cap_valid && (state_q == SEND) && !at_last);
    end

    always_ff @(posedge aclk) begin
        if (reset) begin
            idx_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            overrun_q   <= 1'b0;
            vec_count_q <= '0;
        end else begin
            idx_q       <= idx_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            overrun_q   <= overrun_d;
            vec_count_q <= vec_count_d;
        end
    end

    // The vector buffer needs no reset: it is only read after a capture has filled it.
    always_ff @(posedge aclk) begin
        if (!reset && capture) begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
                word_q[i] <= cap_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign busy      = out_valid_q;
    assign overrun   = overrun_q;
    assign vec_count = vec_count_q;

endmodule

// File: tb/tb_nn_layer_serializer.sv
// Directed self-checking bench for nn_layer_serializer with a 4-word vector.
module tb_nn_layer_serializer;

    localparam int unsigned N  = 4;
    localparam int unsigned DW = 16;
    localparam int unsigned CW = 8;

    logic            aclk = 1'b0;
    logic            reset = 1'b1;
    logic            cap_valid = 1'b0;
    logic [N*DW-1:0] cap_data = '0;
    logic [DW-1:0]   out_data;
    logic            out_valid;
    logic            out_last;
    logic            busy;
    logic            overrun;
    logic [CW-1:0]   vec_count;

    int errors = 0;
    int checks = 0;
    logic [CW-1:0] exp_vc = '0;

    nn_layer_serializer #(
        .NUM_NEURONS(N),
        .DATA_WIDTH (DW),
        .CNT_WIDTH  (CW)
    ) dut (
        .aclk     (aclk),
        .reset    (reset),
        .cap_valid(cap_valid),
        .cap_data (cap_data),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_last (out_last),
        .busy     (busy),
        .overrun  (overrun),
        .vec_count(vec_count)
    );

    always #5 aclk = ~aclk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, got no summary, required completion");
        $fatal(1, "timeout");
    end

    function automatic logic [N*DW-1:0] pack(input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                                             input logic [DW-1:0] w2, input logic [DW-1:0] w3);
        return {w3, w2, w1, w0};
    endfunction

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            cap_valid = c[0] ? 1'b0 : 1'b1;
            cap_data  = pack(16'h1111, 16'h2222, 16'h3333, 16'h4444);
            tick();
            checks++;
            if (out_valid !== 1'b0) begin errors++;
                $display("FAIL reset_valid c=%0d got %b want 0", c, out_valid); end
            checks++;
            if (out_last !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0) begin errors++;
                $display("FAIL reset_flags c=%0d got last=%b busy=%b ovr=%b want 0", c,
                         out_last, busy, overrun); end
            checks++;
            if (out_data !== 16'h0 || vec_count !== 8'h0) begin errors++;
                $display("FAIL reset_data c=%0d got data=%h cnt=%0d want 0", c, out_data,
                         vec_count); end
        end
        reset = 1'b0;
        cap_valid = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++;
            $display("FAIL reset_release got valid=%b want 0", out_valid); end
        exp_vc = '0;
    endtask

    task automatic test_single();
        cap_data  = pack(16'h0001, 16'h0002, 16'h0003, 16'h0004);
        cap_valid = 1'b1;
        tick();
        cap_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (out_valid !== 1'b1 || busy !== 1'b1) begin errors++;
                $display("FAIL single_valid k=%0d got v=%b b=%b want 1", k, out_valid, busy); end
            checks++;
            if (out_data !== DW'(k + 1)) begin errors++;
                $display("FAIL single_data k=%0d got %h want %h", k, out_data, k + 1); end
            checks++;
            if (out_last !== (k == 3)) begin errors++;
                $display("FAIL single_last k=%0d got %b want %b", k, out_last, k == 3); end
            checks++;
            if (vec_count !== exp_vc) begin errors++;
                $display("FAIL single_cnt k=%0d got %0d want %0d", k, vec_count, exp_vc); end
            tick();
        end
        exp_vc++;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 16'h0) begin errors++;
            $display("FAIL single_idle got v=%b b=%b d=%h want 0", out_valid, busy, out_data); end
        checks++;
        if (vec_count !== exp_vc) begin errors++;
            $display("FAIL single_cnt_after got %0d want %0d", vec_count, exp_vc); end
    endtask

    task automatic test_back_to_back();
        cap_data  = pack(16'h0001, 16'h0002, 16'h0003, 16'h0004);
        cap_valid = 1'b1;
        tick();
        cap_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== DW'(k + 1)) begin errors++;
                $display("FAIL b2b_beat k=%0d got v=%b d=%h want v=1 d=%h", k, out_valid,
                         out_data, k + 1); end
            checks++;
            if (out_last !== (k == 3 || k == 7)) begin errors++;
                $display("FAIL b2b_last k=%0d got %b want %b", k, out_last, k == 3 || k == 7); end
            checks++;
            if (overrun !== 1'b0) begin errors++;
                $display("FAIL b2b_overrun k=%0d got %b want 0", k, overrun); end
            checks++;
            if (vec_count !== exp_vc + CW'(k >= 4)) begin errors++;
                $display("FAIL b2b_cnt k=%0d got %0d want %0d", k, vec_count,
                         exp_vc + CW'(k >= 4)); end
            if (k == 3) begin
                cap_valid = 1'b1;
                cap_data  = pack(16'h0005, 16'h0006, 16'h0007, 16'h0008);
            end
            tick();
            cap_valid = 1'b0;
        end
        exp_vc += 2;
        checks++;
        if (out_valid !== 1'b0 || vec_count !== exp_vc) begin errors++;
            $display("FAIL b2b_end got v=%b cnt=%0d want v=0 cnt=%0d", out_valid, vec_count,
                     exp_vc); end
    endtask

    task automatic test_overrun();
        cap_data  = pack(16'h0001, 16'h0002, 16'h0003, 16'h0004);
        cap_valid = 1'b1;
        tick();
        cap_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== DW'(k + 1)) begin errors++;
                $display("FAIL ovr_beat k=%0d got v=%b d=%h want v=1 d=%h", k, out_valid,
                         out_data, k + 1); end
            checks++;
            if (overrun !== (k >= 2)) begin errors++;
                $display("FAIL ovr_flag k=%0d got %b want %b", k, overrun, k >= 2); end
            if (k == 1) begin
                cap_valid = 1'b1;
                cap_data  = {N{16'hFFFF}};
            end
            tick();
            cap_valid = 1'b0;
        end
        exp_vc++;
        repeat (10) tick();
        checks++;
        if (overrun !== 1'b1 || out_valid !== 1'b0) begin errors++;
            $display("FAIL ovr_sticky got ovr=%b v=%b want ovr=1 v=0", overrun, out_valid); end
        checks++;
        if (vec_count !== exp_vc) begin errors++;
            $display("FAIL ovr_cnt got %0d want %0d", vec_count, exp_vc); end
    endtask

    task automatic test_reset_mid();
        cap_data  = pack(16'h0009, 16'h000A, 16'h000B, 16'h000C);
        cap_valid = 1'b1;
        tick();
        cap_valid = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'h000A) begin errors++;
            $display("FAIL mid_beat1 got v=%b d=%h want v=1 d=000a", out_valid, out_data); end
        reset     = 1'b1;
        cap_valid = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || out_last !== 1'b0) begin errors++;
            $display("FAIL mid_reset_flags got v=%b b=%b l=%b want 0", out_valid, busy,
                     out_last); end
        checks++;
        if (vec_count !== 8'h0 || overrun !== 1'b0 || out_data !== 16'h0) begin errors++;
            $display("FAIL mid_reset_state got cnt=%0d ovr=%b d=%h want 0", vec_count, overrun,
                     out_data); end
        reset     = 1'b0;
        cap_valid = 1'b0;
        exp_vc    = '0;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++;
            $display("FAIL mid_cap_ignored got v=%b want 0", out_valid); end
        cap_data  = pack(16'h000A, 16'h000B, 16'h000C, 16'h000D);
        cap_valid = 1'b1;
        tick();
        cap_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== DW'(k + 10) || out_last !== (k == 3))
            begin errors++;
                $display("FAIL mid_restream k=%0d got v=%b d=%h l=%b want v=1 d=%h l=%b", k,
                         out_valid, out_data, out_last, k + 10, k == 3); end
            tick();
        end
        exp_vc++;
        checks++;
        if (vec_count !== exp_vc || overrun !== 1'b0) begin errors++;
            $display("FAIL mid_cnt got cnt=%0d ovr=%b want cnt=%0d ovr=0", vec_count, overrun,
                     exp_vc); end
    endtask

    task automatic test_wrap();
        logic [DW-1:0] wv [N];
        wv = '{16'h8000, 16'h7FFF, 16'h0000, 16'h00FF};
        reset = 1'b1;
        tick();
        reset = 1'b0;
        cap_data  = pack(wv[0], wv[1], wv[2], wv[3]);
        cap_valid = 1'b1;
        tick();
        cap_valid = 1'b0;
        for (int k = 0; k < 256 * N; k++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== wv[k % N]) begin errors++;
                $display("FAIL wrap_beat k=%0d got v=%b d=%h want v=1 d=%h", k, out_valid,
                         out_data, wv[k % N]); end
            checks++;
            if (out_last !== ((k % N) == N - 1)) begin errors++;
                $display("FAIL wrap_last k=%0d got %b want %b", k, out_last, (k % N) == N - 1);
            end
            checks++;
            if (vec_count !== CW'(k / N)) begin errors++;
                $display("FAIL wrap_cnt k=%0d got %0d want %0d", k, vec_count, CW'(k / N)); end
            if ((k % N) == N - 1 && k < 255 * N) cap_valid = 1'b1;
            tick();
            cap_valid = 1'b0;
        end
        checks++;
        if (vec_count !== 8'h0 || out_valid !== 1'b0) begin errors++;
            $display("FAIL wrap_end got cnt=%0d v=%b want cnt=0 v=0", vec_count, out_valid); end
        checks++;
        if (overrun !== 1'b0) begin errors++;
            $display("FAIL wrap_overrun got %b want 0", overrun); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overrun();
        test_reset_mid();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
